// File: rtl/can_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | can_pkg                                                              |
// | Shared CAN types, field lengths, bus levels and CRC-15 step.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package can_pkg;

    localparam logic        CAN_RECESSIVE = 1'b1;
    localparam logic        CAN_DOMINANT  = 1'b0;
    localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;

    localparam logic [6:0]  CAN_ID_LEN    = 7'd11;
    localparam logic [6:0]  CAN_DLC_LEN   = 7'd4;
    localparam logic [6:0]  CAN_CRC_LEN   = 7'd15;
    localparam logic [6:0]  CAN_EOF_LEN   = 7'd7;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SOF      = 4'd1,
        ST_ID       = 4'd2,
        ST_RTR      = 4'd3,
        ST_IDE      = 4'd4,
        ST_R0       = 4'd5,
        ST_DLC      = 4'd6,
        ST_DATA     = 4'd7,
        ST_CRC      = 4'd8,
        ST_CRC_DEL  = 4'd9,
        ST_ACK_SLOT = 4'd10,
        ST_ACK_DEL  = 4'd11,
        ST_EOF      = 4'd12,
        ST_IFS      = 4'd13
    } can_tx_state_e;

    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic din);
        return (din ^ crc[14]) ? ({crc[13:0], 1'b0} ^ CAN_CRC_POLY) : {crc[13:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/can_crc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | can_crc                                                              |
// | Serial CAN CRC-15 accumulator, one bit per enabled bit_tick.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module can_crc
    import can_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        crc_reset,
    input  logic        crc_enable,
    input  logic        bit_tick,
    input  logic        data_in,
    output logic [14:0] crc_out
);

    logic [14:0] r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= '0;
        end else if (crc_reset) begin
            r_crc <= '0;
        end else if (crc_enable && bit_tick) begin
            r_crc <= crc_step(r_crc, data_in);
        end
    end

    assign crc_out = r_crc;

endmodule
`default_nettype wire

// File: rtl/can_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | can_tx_framer                                                        |
// | Standard-format CAN transmit sequencer, SOF through IFS, with CRC.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module can_tx_framer
    import can_pkg::*;
#(
    parameter int IFS_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_tick,
    input  logic        start,
    input  logic [10:0] id,
    input  logic        rtr,
    input  logic [3:0]  dlc,
    input  logic [63:0] data,
    input  logic        rx_bit,
    input  logic        arb_lost,
    output logic        tx_bit,
    output logic        stuff_en,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        arb_abort
);

    can_tx_state_e r_state;
    logic [6:0]    r_cnt;
    logic [10:0]   r_id;
    logic          r_rtr;
    logic [3:0]    r_dlc;
    logic [63:0]   r_data;
    logic [3:0]    r_nbytes;
    logic          r_tx_bit;
    logic          r_stuff_en;
    logic          r_busy;
    logic          r_done;
    logic          r_ack_err;
    logic          r_arb_abort;

    can_tx_state_e w_next_field;
    logic [6:0]    w_len;
    logic          w_last;
    logic [3:0]    w_idx;
    logic          w_first_bit;
    logic          w_next_bit;
    logic          w_next_stuffed;
    logic          w_crc_reset;
    logic          w_crc_enable;
    logic          w_crc_first;
    logic [14:0]   w_crc_out;

    assign w_crc_reset  = (r_state == ST_IDLE) && start;
    assign w_crc_enable = r_state inside {ST_SOF, ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA};
    assign w_idx        = r_cnt[3:0] + 4'd1;
    assign w_last       = (r_cnt == w_len - 7'd1);

    // MSB of the CRC after the last protected bit lands this same tick.
    assign w_crc_first  = w_crc_out[13] ^ ((r_tx_bit ^ w_crc_out[14]) & CAN_CRC_POLY[14]);

    can_crc u_crc (
        .clk        (clk),
        .rst        (rst),
        .crc_reset  (w_crc_reset),
        .crc_enable (w_crc_enable),
        .bit_tick   (bit_tick),
        .data_in    (r_tx_bit),
        .crc_out    (w_crc_out)
    );

    always_comb begin
        w_len        = 7'd1;
        w_next_field = ST_IDLE;
        case (r_state)
            ST_SOF:      w_next_field = ST_ID;
            ST_ID:       begin w_len = CAN_ID_LEN;  w_next_field = ST_RTR; end
            ST_RTR:      w_next_field = ST_IDE;
            ST_IDE:      w_next_field = ST_R0;
            ST_R0:       w_next_field = ST_DLC;
            ST_DLC:      begin
                w_len        = CAN_DLC_LEN;
                w_next_field = (r_nbytes == 4'd0) ? ST_CRC : ST_DATA;
            end
            ST_DATA:     begin w_len = {r_nbytes, 3'b000}; w_next_field = ST_CRC; end
            ST_CRC:      begin w_len = CAN_CRC_LEN; w_next_field = ST_CRC_DEL; end
            ST_CRC_DEL:  w_next_field = ST_ACK_SLOT;
            ST_ACK_SLOT: w_next_field = ST_ACK_DEL;
            ST_ACK_DEL:  w_next_field = ST_EOF;
            ST_EOF:      begin w_len = CAN_EOF_LEN; w_next_field = ST_IFS; end
            ST_IFS:      begin w_len = 7'(IFS_BITS); w_next_field = ST_IDLE; end
            default:     w_next_field = ST_IDLE;
        endcase
    end

    always_comb begin
        w_first_bit = CAN_RECESSIVE;
        case (w_next_field)
            ST_ID:   w_first_bit = r_id[10];
            ST_RTR:  w_first_bit = r_rtr;
            ST_IDE:  w_first_bit = CAN_DOMINANT;
            ST_R0:   w_first_bit = CAN_DOMINANT;
            ST_DLC:  w_first_bit = r_dlc[3];
            ST_DATA: w_first_bit = r_data[63];
            ST_CRC:  w_first_bit = w_crc_first;
            default: w_first_bit = CAN_RECESSIVE;
        endcase
    end

    // Bit at index cnt+1 of a multi-bit field; payload shifts so [62] is next.
    always_comb begin
        w_next_bit = CAN_RECESSIVE;
        case (r_state)
            ST_ID:   w_next_bit = r_id[4'd10 - w_idx];
            ST_DLC:  w_next_bit = r_dlc[2'd3 - w_idx[1:0]];
            ST_DATA: w_next_bit = r_data[62];
            ST_CRC:  w_next_bit = w_crc_out[4'd14 - w_idx];
            default: w_next_bit = CAN_RECESSIVE;
        endcase
    end

    assign w_next_stuffed = w_next_field inside {ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA, ST_CRC};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_id        <= '0;
            r_rtr       <= 1'b0;
            r_dlc       <= '0;
            r_data      <= '0;
            r_nbytes    <= '0;
            r_tx_bit    <= CAN_RECESSIVE;
            r_stuff_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_err   <= 1'b0;
            r_arb_abort <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_arb_abort <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_id       <= id;
                    r_rtr      <= rtr;
                    r_dlc      <= dlc;
                    r_data     <= data;
                    r_nbytes   <= rtr ? 4'd0 : ((dlc > 4'd8) ? 4'd8 : dlc);
                    r_state    <= ST_SOF;
                    r_cnt      <= '0;
                    r_tx_bit   <= CAN_DOMINANT;
                    r_stuff_en <= 1'b1;
                    r_busy     <= 1'b1;
                    r_ack_err  <= 1'b0;
                end
            end else if (bit_tick) begin
                if (arb_lost && (r_state == ST_ID || r_state == ST_RTR)) begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_tx_bit    <= CAN_RECESSIVE;
                    r_stuff_en  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_arb_abort <= 1'b1;
                end else begin
                    if (r_state == ST_ACK_SLOT) begin
                        r_ack_err <= rx_bit;
                    end
                    if (r_state == ST_DATA) begin
                        r_data <= {r_data[62:0], 1'b0};
                    end
                    if (w_last) begin
                        r_state    <= w_next_field;
                        r_cnt      <= '0;
                        r_tx_bit   <= w_first_bit;
                        r_stuff_en <= w_next_stuffed;
                        if (r_state == ST_IFS) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end
                    end else begin
                        r_cnt    <= r_cnt + 7'd1;
                        r_tx_bit <= w_next_bit;
                    end
                end
            end
        end
    end

    assign tx_bit    = r_tx_bit;
    assign stuff_en  = r_stuff_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ack_err   = r_ack_err;
    assign arb_abort = r_arb_abort;

endmodule
`default_nettype wire
